wb_serial_master: RTL and testbench

- Serial-command Wishbone initiator. It turns a byte stream from a UART receive path into single 32-bit Wishbone read/write cycles, and returns response bytes on a UART transmit path.
- It is the bus-master counterpart to the slave peripherals behind the mmu, and serves as a debug/loader port.
- It attaches as an additional master ahead of the data-bus mmu (arbitration is external) and drives `busy` so an arbiter can hold off the CPU.

---
 rtl/wb_serial_pkg.sv | 24 ++
 rtl/if_wb.sv | 23 ++
 rtl/wb_serial_txshift.sv | 42 ++++
 rtl/wb_serial_master.sv | 219 +++++++++++++++++++++
 tb/tb_wb_serial_master.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_serial_pkg.sv
// Shared types and byte constants for the serial-command Wishbone initiator.
package wb_serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_BUS   = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;

  localparam logic [2:0] LEN_BYTE = 3'd1;
  localparam logic [2:0] LEN_WORD = 3'd4;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_READ) || (b == CMD_WRITE);
  endfunction

endpackage

// File: rtl/if_wb.sv
// Classic Wishbone bus bundle; the master modport is seen from the initiator side.
interface if_wb;

  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;

  modport master (
    output cyc, stb, we, sel, adr, dat_o,
    input  dat_i, ack
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_o,
    output dat_i, ack
  );

endinterface

// File: rtl/wb_serial_txshift.sv
// Response serializer: up to four bytes shifted out MSB first under a valid/ready handshake.
module wb_serial_txshift
  import wb_serial_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [2:0]  load_len,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done
);

  logic [31:0] shift_r;
  logic [2:0]  left_r;
  logic        valid_r;

  // Load a response word, then drop one byte per accepted handshake.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shift_r <= 32'h0000_0000;
      left_r  <= 3'd0;
      valid_r <= 1'b0;
    end else if (load) begin
      shift_r <= load_data;
      left_r  <= load_len;
      valid_r <= (load_len != 3'd0);
    end else if (valid_r && tx_ready) begin
      shift_r <= {shift_r[23:0], 8'h00};
      left_r  <= left_r - 3'd1;
      valid_r <= (left_r != LEN_BYTE);
    end
  end

  assign tx_data  = shift_r[31:24];
  assign tx_valid = valid_r;
  // Pulses in the cycle the final byte is accepted.
  assign done     = valid_r && tx_ready && (left_r == LEN_BYTE);

endmodule

// File: rtl/wb_serial_master.sv
// Serial-command Wishbone initiator: 'R'/'W' byte commands become single 32-bit bus cycles.
// Optional ack timeout with 'E' response is enabled by defining WBSER_TIMEOUT_EN.
module wb_serial_master
  import wb_serial_pkg::*;
#(
`ifdef WBSER_TIMEOUT_EN
  parameter int unsigned TIMEOUT = 1024,
`endif
  parameter logic [3:0] SEL_ALL = 4'hf
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  if_wb.master       bus,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       rx_drop
);

`ifdef WBSER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_r;
  logic [TMO_W-1:0] tmo_s;
`endif

  state_e      state_r, state_s;
  logic [1:0]  cnt_r, cnt_s;
  logic        we_r, we_s;
  logic [31:0] adr_r, adr_s;
  logic [31:0] dat_r, dat_s;
  logic        cyc_r, cyc_s;
  logic [3:0]  sel_r, sel_s;
  logic        busy_r, busy_s;
  logic        drop_r, drop_s;

  logic        load_s;
  logic [31:0] load_data_s;
  logic [2:0]  load_len_s;
  logic        tx_done_s;

  // Register the FSM state together with every bus-facing output.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= 2'd0;
      we_r    <= 1'b0;
      adr_r   <= 32'h0000_0000;
      dat_r   <= 32'h0000_0000;
      cyc_r   <= 1'b0;
      sel_r   <= 4'h0;
      busy_r  <= 1'b0;
      drop_r  <= 1'b0;
`ifdef WBSER_TIMEOUT_EN
      tmo_r   <= {TMO_W{1'b0}};
`endif
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      we_r    <= we_s;
      adr_r   <= adr_s;
      dat_r   <= dat_s;
      cyc_r   <= cyc_s;
      sel_r   <= sel_s;
      busy_r  <= busy_s;
      drop_r  <= drop_s;
`ifdef WBSER_TIMEOUT_EN
      tmo_r   <= tmo_s;
`endif
    end
  end

  // Next-state, byte assembly, bus handshake and response launch.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    we_s        = we_r;
    adr_s       = adr_r;
    dat_s       = dat_r;
    cyc_s       = cyc_r;
    sel_s       = sel_r;
    busy_s      = busy_r;
    drop_s      = drop_r;
    load_s      = 1'b0;
    load_data_s = 32'h0000_0000;
    load_len_s  = LEN_BYTE;
`ifdef WBSER_TIMEOUT_EN
    tmo_s       = {TMO_W{1'b0}};
`endif

    // Bytes have no backpressure, so anything arriving mid-transaction is lost and flagged.
    if (rx_valid && ((state_r == ST_BUS) || (state_r == ST_RESP))) begin
      drop_s = 1'b1;
    end else begin
      drop_s = drop_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (rx_valid && is_cmd(rx_data)) begin
          state_s = ST_ADDR;
          we_s    = (rx_data == CMD_WRITE);
          cnt_s   = 2'd0;
          busy_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_ADDR: begin
        if (rx_valid) begin
          adr_s = {adr_r[23:0], rx_data};
          if (cnt_r == 2'd3) begin
            cnt_s = 2'd0;
            if (we_r) begin
              state_s = ST_WDATA;
            end else begin
              state_s = ST_BUS;
              cyc_s   = 1'b1;
              sel_s   = SEL_ALL;
            end
          end else begin
            cnt_s = cnt_r + 2'd1;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end

      ST_WDATA: begin
        if (rx_valid) begin
          dat_s = {dat_r[23:0], rx_data};
          if (cnt_r == 2'd3) begin
            cnt_s   = 2'd0;
            state_s = ST_BUS;
            cyc_s   = 1'b1;
            sel_s   = SEL_ALL;
          end else begin
            cnt_s = cnt_r + 2'd1;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end

      ST_BUS: begin
        // Ack is checked before the timeout so a same-cycle ack still returns data.
        if (bus.ack && cyc_r) begin
          cyc_s       = 1'b0;
          sel_s       = 4'h0;
          load_s      = 1'b1;
          load_data_s = we_r ? {RSP_OK, 24'h00_0000} : bus.dat_i;
          load_len_s  = we_r ? LEN_BYTE : LEN_WORD;
          cnt_s       = 2'd0;
          state_s     = ST_RESP;
        end
`ifdef WBSER_TIMEOUT_EN
        else if (tmo_r == TMO_W'(TIMEOUT - 1)) begin
          cyc_s       = 1'b0;
          sel_s       = 4'h0;
          load_s      = 1'b1;
          load_data_s = {RSP_ERR, 24'h00_0000};
          load_len_s  = LEN_BYTE;
          cnt_s       = 2'd0;
          state_s     = ST_RESP;
        end else begin
          tmo_s = tmo_r + TMO_W'(1);
        end
`else
        else begin
          state_s = ST_BUS;
        end
`endif
      end

      ST_RESP: begin
        if (tx_done_s) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
          cnt_s   = 2'd0;
        end else begin
          state_s = ST_RESP;
        end
      end

      default: begin
        state_s = ST_IDLE;
        cnt_s   = 2'd0;
        cyc_s   = 1'b0;
        sel_s   = 4'h0;
        busy_s  = 1'b0;
      end
    endcase
  end

  wb_serial_txshift u_txshift (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .load      (load_s),
    .load_data (load_data_s),
    .load_len  (load_len_s),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .done      (tx_done_s)
  );

  assign bus.cyc   = cyc_r;
  assign bus.stb   = cyc_r;
  assign bus.we    = we_r;
  assign bus.sel   = sel_r;
  assign bus.adr   = adr_r;
  assign bus.dat_o = dat_r;
  assign busy      = busy_r;
  assign rx_drop   = drop_r;

endmodule

// File: tb/tb_wb_serial_master.sv
// Randomized bench for wb_serial_master against a command-level model (memory, expected bus and tx queues).
module tb_wb_serial_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       rx_drop;

  if_wb wb();

  always #5 clk = ~clk;

  wb_serial_master #(
`ifdef WBSER_TIMEOUT_EN
    .TIMEOUT (16),
`endif
    .SEL_ALL (4'hf)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .bus      (wb),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .rx_drop  (rx_drop)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } txn_t;

  int n_checks = 0;
  int n_errors = 0;

  txn_t        exp_bus[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] slv_mem[logic [31:0]];
  int          exp_stb = 0;
  int          stb_seen = 0;
  int          ack_delay = 1;
  bit          slv_stall = 1'b0;
  int          rdy_low = 0;
  bit          rdy_random = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] default_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : default_word(a);
  endfunction

  // Wishbone slave: acks after ack_delay stb cycles, keeps its own memory, checks each handshake.
  initial begin : bus_slave
    int   waited;
    logic prev_stb;
    txn_t t;
    waited   = 0;
    prev_stb = 1'b0;
    wb.ack   = 1'b0;
    wb.dat_i = 32'h0;
    forever begin
      @(negedge clk);
      if (wb.stb && !prev_stb) stb_seen++;
      prev_stb = wb.stb;
      if (!rst_n) begin
        wb.ack = 1'b0;
        waited = 0;
      end else if (wb.ack) begin
        wb.ack   = 1'b0;
        wb.dat_i = $urandom;
        waited   = 0;
      end else if (wb.cyc && wb.stb && !slv_stall) begin
        if (waited >= ack_delay) begin
          if (exp_bus.size() == 0) begin
            check_eq("bus_unexpected", 32'd1, 32'd0);
          end else begin
            t = exp_bus.pop_front();
            check_eq("bus_we", {31'd0, wb.we}, {31'd0, t.we});
            check_eq("bus_adr", wb.adr, t.adr);
            check_eq("bus_sel", {28'd0, wb.sel}, 32'hf);
            if (t.we) check_eq("bus_dat", wb.dat_o, t.dat);
          end
          if (wb.we) slv_mem[wb.adr] = wb.dat_o;
          wb.dat_i = slv_mem.exists(wb.adr) ? slv_mem[wb.adr] : default_word(wb.adr);
          wb.ack   = 1'b1;
        end else begin
          waited++;
        end
      end else begin
        waited = 0;
      end
    end
  end

  // Transmit sink: drives tx_ready, checks accepted bytes in order and stability while stalled.
  initial begin : tx_sink
    bit         held;
    logic [7:0] held_data;
    held      = 1'b0;
    held_data = 8'h00;
    tx_ready  = 1'b0;
    forever begin
      @(negedge clk);
      if (held) begin
        check_eq("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
        check_eq("tx_hold_data", {24'd0, tx_data}, {24'd0, held_data});
      end
      if (rdy_low > 0) begin
        tx_ready = 1'b0;
        if (tx_valid) rdy_low--;
      end else if (rdy_random) begin
        tx_ready = ($urandom_range(0, 2) != 0);
      end else begin
        tx_ready = 1'b1;
      end
      if (tx_valid && tx_ready && rst_n) begin
        if (exp_tx.size() == 0) check_eq("tx_unexpected", 32'd1, 32'd0);
        else check_eq("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
      end
      held      = tx_valid && !tx_ready && rst_n;
      held_data = tx_data;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Called at a negedge: one byte per cycle, no gaps.
  task automatic send_bytes(input logic [7:0] b[$]);
    foreach (b[i]) begin
      rx_data  = b[i];
      rx_valid = 1'b1;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    rx_data  = $urandom;
  endtask

  task automatic issue(input bit we, input logic [31:0] adr, input logic [31:0] dat, input bit extra);
    logic [7:0]  b[$];
    logic [31:0] rd;
    txn_t        t;
    b.push_back(we ? 8'h57 : 8'h52);
    for (int i = 3; i >= 0; i--) b.push_back(adr[8*i +: 8]);
    if (we) for (int i = 3; i >= 0; i--) b.push_back(dat[8*i +: 8]);
    if (extra) b.push_back(8'($urandom));
    t.we  = we;
    t.adr = adr;
    t.dat = we ? dat : 32'h0;
    exp_bus.push_back(t);
    exp_stb++;
    if (we) begin
      ref_mem[adr] = dat;
      exp_tx.push_back(8'h4B);
    end else begin
      rd = ref_read(adr);
      for (int i = 3; i >= 0; i--) exp_tx.push_back(rd[8*i +: 8]);
    end
    send_bytes(b);
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!busy && !tx_valid && exp_tx.size() == 0 && exp_bus.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin : main
    logic [7:0]  g[$];
    logic [31:0] pool[4];
    logic [31:0] a;
    int          s;
    int          n;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_cyc", {31'd0, wb.cyc}, 32'd0);
    check_eq("rst_stb", {31'd0, wb.stb}, 32'd0);
    check_eq("rst_we", {31'd0, wb.we}, 32'd0);
    check_eq("rst_sel", {28'd0, wb.sel}, 32'd0);
    check_eq("rst_adr", wb.adr, 32'd0);
    check_eq("rst_dat", wb.dat_o, 32'd0);
    check_eq("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_rx_drop", {31'd0, rx_drop}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    ack_delay = 1;
    issue(1'b1, 32'h0000_3004, 32'hDEAD_BEEF, 1'b0);
    wait_idle("write_done");

    ref_mem[32'h0000_3000] = 32'h1234_5678;
    slv_mem[32'h0000_3000] = 32'h1234_5678;
    rdy_low = 5;
    issue(1'b0, 32'h0000_3000, 32'h0, 1'b0);
    wait_idle("read_hold_done");

    issue(1'b0, 32'h0000_3000, 32'h0, 1'b0);
    n = 1;
    while (!tx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("read_latency", n, 32'd3);
    wait_idle("latency_done");

    s = stb_seen;
    g.push_back(8'h00);
    g.push_back(8'hFF);
    send_bytes(g);
    repeat (6) @(negedge clk);
    check_eq("garbage_stb", stb_seen, s);
    check_eq("garbage_tx", {31'd0, tx_valid}, 32'd0);
    check_eq("garbage_busy", {31'd0, busy}, 32'd0);
    check_eq("garbage_drop", {31'd0, rx_drop}, 32'd0);

    ack_delay = 2;
    issue(1'b0, 32'h0000_0120, 32'h0, 1'b1);
    wait_idle("drop_done");
    check_eq("drop_set", {31'd0, rx_drop}, 32'd1);

    slv_stall = 1'b1;
    issue(1'b0, 32'h0000_0040, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("pre_rst_cyc", {31'd0, wb.cyc}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_cyc", {31'd0, wb.cyc}, 32'd0);
    check_eq("mid_rst_stb", {31'd0, wb.stb}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_drop", {31'd0, rx_drop}, 32'd0);
    exp_bus.delete();
    exp_tx.delete();
    slv_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("post_rst_tx", {31'd0, tx_valid}, 32'd0);
    issue(1'b0, 32'h0000_3000, 32'h0, 1'b0);
    wait_idle("post_rst_read");

    s = stb_seen;
    a = $urandom;
    issue(1'b1, a, $urandom, 1'b0);
    wait_idle("b2b_write");
    issue(1'b0, a, 32'h0, 1'b0);
    wait_idle("b2b_read");
    check_eq("b2b_stb_count", stb_seen - s, 32'd2);

    pool[0] = 32'h0000_3004;
    pool[1] = 32'h8000_0000;
    pool[2] = $urandom;
    pool[3] = $urandom;
    rdy_random = 1'b1;
    for (int i = 0; i < 30; i++) begin
      ack_delay = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        g.delete();
        g.push_back(8'($urandom));
        if (g[0] == 8'h52 || g[0] == 8'h57) g[0] = 8'h00;
        send_bytes(g);
      end
      issue(1'($urandom), pool[$urandom_range(0, 3)], $urandom, ($urandom_range(0, 7) == 0));
      wait_idle("rand_done");
    end
    rdy_random = 1'b0;

`ifdef WBSER_TIMEOUT_EN
    slv_stall = 1'b1;
    issue(1'b0, 32'h0000_0500, 32'h0, 1'b0);
    exp_bus.delete();
    exp_tx.delete();
    exp_tx.push_back(8'h45);
    n = 0;
    while (wb.cyc && n < 100) begin
      n++;
      @(negedge clk);
    end
    check_eq("timeout_cycles", n, 32'd16);
    wait_idle("timeout_done");
    slv_stall = 1'b0;
    ack_delay = 15;
    issue(1'b0, 32'h0000_0504, 32'h0, 1'b0);
    wait_idle("late_ack_done");
`endif

    repeat (3) @(negedge clk);
    check_eq("stb_total", stb_seen, exp_stb);
    check_eq("bus_queue_empty", exp_bus.size(), 32'd0);
    check_eq("tx_queue_empty", exp_tx.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
